vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_if.sv | 14 +
 rtl/vga_timing_gen.sv | 102 ++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Video timing bundle: raster position, active-area flag, pixel strobe and syncs.
// The generator drives it through the master modport; consumers use the slave modport.
interface vga_timing_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       en;
  logic       pix_tick;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (output x, y, en, pix_tick, hsync, vsync, frame_start);
  modport slave  (input  x, y, en, pix_tick, hsync, vsync, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk into pixel ticks, walks h/v counters,
// and emits registered position, active-area flag, delayed active-low syncs and a frame pulse.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input logic         clk,
  input logic         reset,
  vga_timing_if.master o_vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]  r_div;
  logic [9:0]        r_h_cnt;
  logic [9:0]        r_v_cnt;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic              r_en;
  logic              r_pix_tick;
  logic              r_frame_start;
  logic [SYNC_DELAY:0] r_hs_pipe;
  logic [SYNC_DELAY:0] r_vs_pipe;

  logic w_tick;
  logic w_hs_raw;
  logic w_vs_raw;

  assign w_tick   = (r_div == DIV_MAX);
  assign w_hs_raw = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign w_vs_raw = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));

  // Counters advance on the tick edge; outputs trail them by one clk, so x changes
  // on the clk after pix_tick and then holds for CLK_DIV clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_en          <= 1'b0;
      r_pix_tick    <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_pipe     <= '1;
      r_vs_pipe     <= '1;
    end else begin
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      r_pix_tick <= w_tick;
      if (w_tick) begin
        if (r_h_cnt == H_MAX) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
      r_x  <= r_h_cnt;
      r_y  <= r_v_cnt;
      r_en <= (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
      // Only a wrap from the last pixel of the last line reaches (0,0) from (H_MAX,V_MAX),
      // so reset release, which starts from x=y=0, never pulses.
      r_frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0) &&
                       (r_x == H_MAX) && (r_y == V_MAX);
      r_hs_pipe[0] <= w_hs_raw;
      r_vs_pipe[0] <= w_vs_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end
  end

  assign o_vga.x           = r_x;
  assign o_vga.y           = r_y;
  assign o_vga.en          = r_en;
  assign o_vga.pix_tick    = r_pix_tick;
  assign o_vga.hsync       = r_hs_pipe[SYNC_DELAY];
  assign o_vga.vsync       = r_vs_pipe[SYNC_DELAY];
  assign o_vga.frame_start = r_frame_start;

endmodule
